// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the main pipeline with a buffered
// long-latency result stream, with anti-starvation priority for the FIFO head.
module writeback_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PipeValid,
    input  logic        PipeRegWrite,
    input  logic [4:0]  PipeRd,
    input  logic [31:0] PipeData,
    output logic        PipeAccept,
    input  logic        LongValid,
    input  logic [4:0]  LongRd,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    output logic [31:0] PendingMask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [4:0]       ent_rd_q   [FIFO_DEPTH];
    logic [4:0]       ent_rd_d   [FIFO_DEPTH];
    logic [31:0]      ent_data_q [FIFO_DEPTH];
    logic [31:0]      ent_data_d [FIFO_DEPTH];
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [31:0]      write_data_q, write_data_d;
    logic [31:0]      pending_mask_q, pending_mask_d;

    logic             fifo_empty, fifo_full, starve_prio, pipe_wr;
    logic             long_acc, long_live, pop, push, bypass;
    logic [PTR_W-1:0] offset;

    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
        starve_prio = !fifo_empty && (starve_cnt_q >= SW'(STARVE_LIMIT));
        pipe_wr     = PipeValid && PipeRegWrite && (PipeRd != 5'd0);
        PipeAccept  = PipeValid && !starve_prio;
        LongReady   = !fifo_full && !rst;
        long_acc    = LongValid && LongReady;
        long_live   = long_acc && (LongRd != 5'd0);

        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        pop          = 1'b0;
        bypass       = 1'b0;

        // Head drains whenever it is starving or the pipe has nothing to write.
        if (starve_prio || (!pipe_wr && !fifo_empty)) begin
            pop          = 1'b1;
            reg_write_d  = 1'b1;
            write_addr_d = ent_rd_q[rd_ptr_q];
            write_data_d = ent_data_q[rd_ptr_q];
        end else if (pipe_wr) begin
            reg_write_d  = 1'b1;
            write_addr_d = PipeRd;
            write_data_d = PipeData;
        end else if (long_live) begin
            bypass       = 1'b1;
            reg_write_d  = 1'b1;
            write_addr_d = LongRd;
            write_data_d = LongData;
        end
        push = long_live && !bypass;

        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        if (push) begin
            ent_rd_d[wr_ptr_q]   = LongRd;
            ent_data_d[wr_ptr_q] = LongData;
        end

        if (pop) begin
            starve_cnt_d = '0;
        end else if (!fifo_empty) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        // Rebuilt from the next FIFO contents so duplicates stay set until the last pops.
        pending_mask_d = '0;
        offset         = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_d;
            if ({1'b0, offset} < count_d) begin
                pending_mask_d[ent_rd_d[i]] = 1'b1;
            end
        end
        pending_mask_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            starve_cnt_q   <= '0;
            reg_write_q    <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            pending_mask_q <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            starve_cnt_q   <= starve_cnt_d;
            reg_write_q    <= reg_write_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            pending_mask_q <= pending_mask_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_rd_q   <= ent_rd_d;
        ent_data_q <= ent_data_d;
    end

    assign RegWrite    = reg_write_q;
    assign WriteAddr   = write_addr_q;
    assign WriteData   = write_data_q;
    assign PendingMask = pending_mask_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based model predicts each
// register write and its cycle; a monitor pops and compares as writes appear.
module tb_writeback_arbiter;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        PipeValid, PipeRegWrite, PipeAccept;
    logic [4:0]  PipeRd;
    logic [31:0] PipeData;
    logic        LongValid, LongReady;
    logic [4:0]  LongRd;
    logic [31:0] LongData;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [31:0] PendingMask;

    typedef struct {
        int          stamp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    wr_t  exp_q[$];
    ent_t fifo_m[$];
    int   wait_m      = 0;
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    writeback_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PipeValid   (PipeValid),
        .PipeRegWrite(PipeRegWrite),
        .PipeRd      (PipeRd),
        .PipeData    (PipeData),
        .PipeAccept  (PipeAccept),
        .LongValid   (LongValid),
        .LongRd      (LongRd),
        .LongData    (LongData),
        .LongReady   (LongReady),
        .RegWrite    (RegWrite),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .PendingMask (PendingMask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back('{stamp: cyc + 1, addr: addr, data: data});
    endtask

    // One cycle: drive inputs, check combinational/registered outputs against the
    // model, advance the model, then wait for the next falling edge.
    task automatic applyStimulus(input logic r, input logic pv, input logic prw,
                                 input logic [4:0] prd, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        int          sz;
        bit          starve, ready, pwr, lacc, popped, bypass;
        logic [31:0] mask;
        ent_t        e;
        rst = r; PipeValid = pv; PipeRegWrite = prw; PipeRd = prd; PipeData = pd;
        LongValid = lv; LongRd = lrd; LongData = ld;
        #1;
        if (r) begin
            checkOutput("LongReady_in_reset", 32'(LongReady), 32'd0);
            fifo_m.delete();
            wait_m = 0;
        end else begin
            sz     = fifo_m.size();
            starve = (sz > 0) && (wait_m >= STARVE_LIMIT);
            ready  = (sz < FIFO_DEPTH);
            pwr    = pv && prw && (prd != 5'd0);
            lacc   = lv && ready;
            popped = 1'b0;
            bypass = 1'b0;
            mask   = 32'd0;
            foreach (fifo_m[i]) mask[fifo_m[i].rd] = 1'b1;
            checkOutput("PipeAccept", 32'(PipeAccept), 32'(pv && !starve));
            checkOutput("LongReady", 32'(LongReady), 32'(ready));
            checkOutput("PendingMask", PendingMask, mask);
            if (starve || (!pwr && sz > 0)) begin
                e = fifo_m.pop_front();
                expectWrite(e.rd, e.data);
                popped = 1'b1;
            end else if (pwr) begin
                expectWrite(prd, pd);
            end else if (lacc && lrd != 5'd0) begin
                expectWrite(lrd, ld);
                bypass = 1'b1;
            end
            if (lacc && lrd != 5'd0 && !bypass) fifo_m.push_back('{rd: lrd, data: ld});
            if (popped) wait_m = 0;
            else if (sz > 0) wait_m++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: every write the DUT presents must match the oldest prediction,
    // including the cycle it was due; overdue predictions count as lost writes.
    always @(negedge clk) begin
        wr_t w;
        while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
            w = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_write: got none, expected x%0d=0x%0h at cycle %0d",
                     w.addr, w.data, w.stamp);
        end
        if (RegWrite === 1'b1) begin
            checkOutput("write_addr_nonzero", 32'(WriteAddr != 5'd0), 32'd1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got x%0d=0x%0h, expected no write (cycle %0d)",
                         WriteAddr, WriteData, cyc);
            end else begin
                w = exp_q.pop_front();
                checkOutput("write_cycle", 32'(cyc), 32'(w.stamp));
                checkOutput("write_addr", 32'(WriteAddr), 32'(w.addr));
                checkOutput("write_data", WriteData, w.data);
            end
        end
    end

    initial begin
        rst = 1'b1; PipeValid = 1'b0; PipeRegWrite = 1'b0; PipeRd = '0; PipeData = '0;
        LongValid = 1'b0; LongRd = '0; LongData = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("reset_RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("reset_WriteAddr", 32'(WriteAddr), 32'd0);
        checkOutput("reset_WriteData", WriteData, 32'd0);
        checkOutput("reset_PendingMask", PendingMask, 32'd0);

        $display("[TB] pipe write x5");
        applyStimulus(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        idle(2);

        $display("[TB] pipe x3 with long x7 in the same cycle");
        applyStimulus(0, 1, 1, 5'd3, 32'h0000_0333, 1, 5'd7, 32'h0000_0777);
        idle(3);

        $display("[TB] starvation of x9 under continuous pipe writes");
        applyStimulus(0, 1, 1, 5'd1, 32'h1000_0001, 1, 5'd9, 32'h9999_9999);
        for (int k = 0; k < 8; k++)
            applyStimulus(0, 1, 1, 5'(2 + k), 32'h2000_0000 + 32'(k), 0, 5'd0, 32'd0);
        idle(2);

        $display("[TB] full FIFO under continuous pipe writes");
        for (int k = 0; k < 14; k++)
            applyStimulus(0, 1, 1, 5'(10 + k), 32'h3000_0000 + 32'(k),
                          1, 5'(20 + (k % 8)), 32'h4000_0000 + 32'(k));
        idle(4);

        $display("[TB] register 0 targets and reset with entries buffered");
        applyStimulus(0, 1, 1, 5'd0, 32'h5555_5555, 1, 5'd0, 32'h6666_6666);
        applyStimulus(0, 1, 0, 5'd4, 32'h7777_7777, 0, 5'd0, 32'd0);
        applyStimulus(0, 1, 1, 5'd11, 32'h0B0B_0B0B, 1, 5'd12, 32'h0C0C_0C0C);
        applyStimulus(0, 1, 1, 5'd13, 32'h0D0D_0D0D, 1, 5'd12, 32'h0E0E_0E0E);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 1, 5'd15, 32'h0F0F_0F0F);
        checkOutput("PendingMask_after_reset", PendingMask, 32'd0);
        idle(4);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0,
                          5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 1) != 0,
                          ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          $urandom);
        end

        for (int k = 0; k < 40 && (fifo_m.size() > 0 || exp_q.size() > 0); k++) idle(1);
        idle(2);
        checkOutput("drain_outstanding_writes", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
